// File: rtl/adc_spi_reader_pkg.sv
// Shared SPI link definitions: FSM states, clock polarity/phase names, sck edge kinds.
package adc_spi_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_XFER,
        ST_DONE
    } spi_state_t;

    localparam logic CPOL_LOW   = 1'b0;
    localparam logic CPOL_HIGH  = 1'b1;
    localparam logic CPHA_LEAD  = 1'b0;
    localparam logic CPHA_TRAIL = 1'b1;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_LEAD,
        EDGE_TRAIL
    } sck_edge_t;

    // True when this sck edge is the one on which miso is captured for the given phase.
    function automatic logic is_sample_edge(input sck_edge_t e, input logic phase);
        return ((e == EDGE_LEAD)  && (phase == CPHA_LEAD)) ||
               ((e == EDGE_TRAIL) && (phase == CPHA_TRAIL));
    endfunction

endpackage

// File: rtl/adc_spi_reader_spi_master.sv
// Generic read-only SPI engine: generates WID sck periods while run is high and
// shifts miso in MSB-first on the sampling edge. Dropping run clears the engine
// and parks sck at its idle level on the next clock.
module spi_master_no_write
    import adc_spi_reader_pkg::*;
#(
    parameter logic POLARITY  = CPOL_HIGH,
    parameter logic PHASE     = CPHA_LEAD,
    parameter int   WID       = 18,
    parameter int   WID_LEN   = 5,
    parameter int   SCK_HALF  = 2,
    parameter int   TIMER_WID = 8
) (
    input  logic           clk,
    input  logic           rst_L,
    input  logic           run,
    input  logic           miso,
    output logic           sck,
    output logic [WID-1:0] shreg,
    output logic           done
);

    logic [TIMER_WID-1:0] half_cnt;
    logic [WID_LEN-1:0]   bit_cnt;
    logic                 lead_next;
    sck_edge_t            edge_c;

    // Decide whether this cycle ends a half-period and which kind of edge it is.
    always_comb begin
        edge_c = EDGE_NONE;
        if (run && !done && (half_cnt == TIMER_WID'(SCK_HALF - 1)))
            edge_c = lead_next ? EDGE_LEAD : EDGE_TRAIL;
    end

    // sck generation, capture and the saturating bit counter; done stops all toggling.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            half_cnt  <= '0;
            bit_cnt   <= '0;
            lead_next <= 1'b1;
            sck       <= POLARITY;
            done      <= 1'b0;
            shreg     <= '0;
        end else if (!run) begin
            half_cnt  <= '0;
            bit_cnt   <= '0;
            lead_next <= 1'b1;
            sck       <= POLARITY;
            done      <= 1'b0;
        end else if (!done) begin
            if (edge_c != EDGE_NONE) begin
                half_cnt  <= '0;
                sck       <= ~sck;
                lead_next <= ~lead_next;
            end else begin
                half_cnt  <= half_cnt + 1'b1;
            end
            if (is_sample_edge(edge_c, PHASE))
                shreg <= {shreg[WID-2:0], miso};
            // A full period ends on the trailing edge; the last one returns sck to idle.
            if (edge_c == EDGE_TRAIL) begin
                if (bit_cnt == WID_LEN'(WID - 1))
                    done <= 1'b1;
                else
                    bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_spi_reader.sv
// ADC read master: on arm, raises adc_conv, waits the conversion time, clocks in
// one sample through the SPI engine, then presents it with finished until arm drops.
module adc_spi_reader
    import adc_spi_reader_pkg::*;
#(
    parameter int   ADC_WID      = 18,
    parameter int   WID_LEN      = 5,
    parameter logic ADC_POLARITY = CPOL_HIGH,
    parameter logic ADC_PHASE    = CPHA_LEAD,
    parameter int   CONV_WAIT    = 16,
    parameter int   SCK_HALF     = 2,
    parameter int   TIMER_WID    = 8
) (
    input  logic                      clk,
    input  logic                      rst_L,
    input  logic                      arm,
    output logic                      adc_conv,
    output logic                      adc_sck,
    input  logic                      adc_in,
    output logic signed [ADC_WID-1:0] data_out,
    output logic                      finished
);

    spi_state_t           state_q, state_n;
    logic [TIMER_WID-1:0] timer_q, timer_n;
    logic                 conv_n, fin_n, load_data;
    logic                 run;
    logic                 xfer_done;
    logic [ADC_WID-1:0]   shreg;

    // Engine runs only in XFER with arm still high, so an abort parks sck on the same edge.
    assign run = (state_q == ST_XFER) && arm;

    spi_master_no_write #(
        .POLARITY  (ADC_POLARITY),
        .PHASE     (ADC_PHASE),
        .WID       (ADC_WID),
        .WID_LEN   (WID_LEN),
        .SCK_HALF  (SCK_HALF),
        .TIMER_WID (TIMER_WID)
    ) u_spi (
        .clk   (clk),
        .rst_L (rst_L),
        .run   (run),
        .miso  (adc_in),
        .sck   (adc_sck),
        .shreg (shreg),
        .done  (xfer_done)
    );

    // Next state, next registered outputs and conversion timer.
    always_comb begin
        state_n   = state_q;
        timer_n   = timer_q;
        conv_n    = adc_conv;
        fin_n     = finished;
        load_data = 1'b0;
        case (state_q)
            ST_IDLE: begin
                conv_n = 1'b0;
                fin_n  = 1'b0;
                if (arm) begin
                    state_n = ST_CONV;
                    conv_n  = 1'b1;
                    timer_n = TIMER_WID'(CONV_WAIT - 1);
                end
            end
            ST_CONV: begin
                if (!arm) begin
                    state_n = ST_IDLE;
                    conv_n  = 1'b0;
                end else if (timer_q == '0) begin
                    state_n = ST_XFER;
                end else begin
                    timer_n = timer_q - 1'b1;
                end
            end
            ST_XFER: begin
                if (!arm) begin
                    state_n = ST_IDLE;
                    conv_n  = 1'b0;
                end else if (xfer_done) begin
                    state_n   = ST_DONE;
                    conv_n    = 1'b0;
                    fin_n     = 1'b1;
                    load_data = 1'b1;
                end
            end
            ST_DONE: begin
                if (!arm) begin
                    state_n = ST_IDLE;
                    fin_n   = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                conv_n  = 1'b0;
                fin_n   = 1'b0;
            end
        endcase
    end

    // State and conversion timer registers.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
        end
    end

    // Registered handshake outputs; data_out only changes on a completed read.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            adc_conv <= 1'b0;
            finished <= 1'b0;
            data_out <= '0;
        end else begin
            adc_conv <= conv_n;
            finished <= fin_n;
            if (load_data)
                data_out <= $signed(shreg);
        end
    end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: two instances (CPOL1/CPHA0 defaults, CPOL0/CPHA1),
// each fed by a behavioural read-only SPI slave.
module tb_adc_spi_reader;

    localparam int W         = 18;
    localparam int CONV_WAIT = 16;
    localparam int SCK_HALF  = 2;
    localparam int LAT       = 1 + CONV_WAIT + 2 * SCK_HALF * W;
    localparam int BOUND     = LAT + 50;

    logic clk = 1'b0;
    logic rst_L;
    logic arm_a, arm_b;
    logic conv_a, conv_b, sck_a, sck_b, fin_a, fin_b;
    logic miso_a = 1'b0, miso_b = 1'b0;
    logic signed [W-1:0] data_a, data_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adc_spi_reader u_dut_a (
        .clk(clk), .rst_L(rst_L), .arm(arm_a), .adc_conv(conv_a), .adc_sck(sck_a),
        .adc_in(miso_a), .data_out(data_a), .finished(fin_a)
    );

    adc_spi_reader #(.ADC_PHASE(1'b1), .ADC_POLARITY(1'b0)) u_dut_b (
        .clk(clk), .rst_L(rst_L), .arm(arm_b), .adc_conv(conv_b), .adc_sck(sck_b),
        .adc_in(miso_b), .data_out(data_b), .finished(fin_b)
    );

    // Slave A (idle-high sck, sampled on leading edge): first bit ready at select,
    // next bit after each trailing edge.
    logic [W-1:0] word_a, sh_a;
    logic psck_a = 1'b1, pconv_a = 1'b0;
    int edges_a = 0, samp_a = 0;
    always @(negedge clk) begin
        if (conv_a && !pconv_a) begin
            sh_a = word_a; miso_a = sh_a[W-1]; edges_a = 0; samp_a = 0;
        end else if (sck_a != psck_a) begin
            edges_a++;
            if (sck_a == 1'b0) samp_a++;
            else if (conv_a) begin sh_a = sh_a << 1; miso_a = sh_a[W-1]; end
        end
        pconv_a = conv_a; psck_a = sck_a;
    end

    // Slave B (idle-low sck, sampled on trailing edge): new bit after each leading edge.
    logic [W-1:0] word_b, sh_b;
    logic psck_b = 1'b0, pconv_b = 1'b0;
    int edges_b = 0, samp_b = 0;
    always @(negedge clk) begin
        if (conv_b && !pconv_b) begin
            sh_b = word_b; miso_b = 1'b0; edges_b = 0; samp_b = 0;
        end else if (sck_b != psck_b) begin
            edges_b++;
            if (sck_b == 1'b1) begin miso_b = sh_b[W-1]; sh_b = sh_b << 1; end
            else samp_b++;
        end
        pconv_b = conv_b; psck_b = sck_b;
    end

    function automatic logic fin_of(input bit b);  return b ? fin_b  : fin_a;  endfunction
    function automatic logic conv_of(input bit b); return b ? conv_b : conv_a; endfunction
    function automatic logic [W-1:0] data_of(input bit b); return b ? data_b : data_a; endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_arm(input bit b, input logic v);
        if (b) arm_b = v; else arm_a = v;
    endtask

    // Full read: latency, adc_conv shape, sample value and edge counts.
    task automatic do_read(input bit b, input logic [W-1:0] w, input logic [W-1:0] exp, input string nm);
        int lat;
        bit conv_bad;
        lat = -1;
        conv_bad = 1'b0;
        if (b) word_b = w; else word_a = w;
        @(negedge clk); set_arm(b, 1'b1);
        @(posedge clk);
        for (int n = 1; n <= BOUND; n++) begin
            @(posedge clk); #1;
            if (fin_of(b)) begin lat = n; break; end
            if (!conv_of(b)) conv_bad = 1'b1;
        end
        check({nm, " latency"}, lat, LAT);
        check({nm, " conv held"}, 32'(conv_bad), 0);
        check({nm, " conv low at done"}, 32'(conv_of(b)), 0);
        check({nm, " data"}, 32'(data_of(b)), 32'(exp));
        check({nm, " sampling edges"}, b ? samp_b : samp_a, W);
        check({nm, " sck edges"}, b ? edges_b : edges_a, 2 * W);
    endtask

    task automatic release_arm(input bit b, input string nm);
        @(negedge clk); set_arm(b, 1'b0);
        @(posedge clk); #1;
        check({nm, " finished drop"}, 32'(fin_of(b)), 0);
    endtask

    typedef struct {
        bit           inst;
        logic [W-1:0] word;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [W-1:0] prev, w;
        bit bad;
        vec_t v;

        rst_L = 1'b0; arm_a = 1'b0; arm_b = 1'b0; word_a = '0; word_b = '0;
        repeat (3) @(posedge clk); #1;
        check("reset conv", 32'(conv_a), 0);
        check("reset sck a", 32'(sck_a), 1);
        check("reset sck b", 32'(sck_b), 0);
        check("reset finished", 32'(fin_a), 0);
        check("reset data", 32'(data_a), 0);
        @(negedge clk); rst_L = 1'b1;

        // Negative full-scale-ish sample on the default instance.
        do_read(1'b0, 18'h2A5A5, 18'h2A5A5, "t1");
        check("t1 negative", 32'($signed(data_a) < 0), 1);
        release_arm(1'b0, "t1");

        // Other mode, back-to-back with a single arm-low cycle.
        do_read(1'b1, 18'h1FFFF, 18'h1FFFF, "t2a");
        release_arm(1'b1, "t2a");
        do_read(1'b1, 18'h00001, 18'h00001, "t2b");
        release_arm(1'b1, "t2b");

        // Table: boundary words plus randomized words on both instances.
        v.inst = 1'b0; v.word = 18'h20000; v.exp_data = 18'h20000; tbl.push_back(v);
        v.inst = 1'b1; v.word = 18'h3FFFF; v.exp_data = 18'h3FFFF; tbl.push_back(v);
        v.inst = 1'b0; v.word = 18'h00000; v.exp_data = 18'h00000; tbl.push_back(v);
        v.inst = 1'b1; v.word = 18'h20001; v.exp_data = 18'h20001; tbl.push_back(v);
        for (int i = 0; i < 6; i++) begin
            w = W'($urandom);
            v.inst = i[0]; v.word = w; v.exp_data = w; tbl.push_back(v);
        end
        foreach (tbl[i]) begin
            do_read(tbl[i].inst, tbl[i].word, tbl[i].exp_data, $sformatf("vec%0d", i));
            release_arm(tbl[i].inst, $sformatf("vec%0d", i));
        end

        // Abort at bit 9 of the transfer.
        do_read(1'b0, 18'h15A5A, 18'h15A5A, "t3 pre");
        release_arm(1'b0, "t3 pre");
        prev = data_a;
        word_a = 18'h0F0F0;
        @(negedge clk); arm_a = 1'b1;
        @(posedge clk);
        repeat (CONV_WAIT + 2 * SCK_HALF * 9) @(posedge clk);
        @(negedge clk); arm_a = 1'b0;
        @(posedge clk); #1;
        check("t3 abort conv", 32'(conv_a), 0);
        check("t3 abort sck", 32'(sck_a), 1);
        check("t3 abort finished", 32'(fin_a), 0);
        check("t3 abort data", 32'(data_a), 32'(prev));
        bad = 1'b0;
        repeat (100) begin @(posedge clk); #1; if (fin_a || conv_a) bad = 1'b1; end
        check("t3 stays idle", 32'(bad), 0);
        do_read(1'b0, 18'h0F0F0, 18'h0F0F0, "t3 post");
        release_arm(1'b0, "t3 post");

        // Reset pulse mid-transfer.
        word_a = 18'h33333;
        @(negedge clk); arm_a = 1'b1;
        repeat (40) @(posedge clk);
        #2 rst_L = 1'b0;
        #1;
        check("t4 conv", 32'(conv_a), 0);
        check("t4 sck", 32'(sck_a), 1);
        check("t4 finished", 32'(fin_a), 0);
        check("t4 data", 32'(data_a), 0);
        check("t4 data b", 32'(data_b), 0);
        arm_a = 1'b0;
        @(negedge clk); rst_L = 1'b1;
        do_read(1'b0, 18'h33333, 18'h33333, "t4 post");

        // Hold arm 200 cycles after finished.
        bad = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (!fin_a || data_a !== 18'sh33333 || sck_a !== 1'b1 || conv_a) bad = 1'b1;
        end
        check("t5 hold stable", 32'(bad), 0);
        check("t5 no extra edges", edges_a, 2 * W);
        release_arm(1'b0, "t5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
